// File: rtl/intr_seq.sv
// ----------------------------------------------------------------------------
// intr_seq : interrupt / reset entry sequencer for the MC6502 core.
//
// Arbitrates RESET, NMI, IRQ and BRK at instruction boundaries and drives the
// 7-cycle entry sequence (two dummy reads, PCH/PCL/P pushes, vector fetch).
// While o_busy=1 its address, data-select and PC-load controls replace the
// decoder's.
//
// Ports
//   i_clk      clock, rising edge
//   i_res_n    asynchronous active-low reset
//   i_rdy      1=advance; 0 stalls read steps only
//   i_sync     opcode-fetch boundary
//   i_nmi_n    NMI, falling-edge sensitive
//   i_irq_n    IRQ, level, active-low
//   i_i_flag   current P.I
//   i_brk_req  decoder has decoded BRK (valid with i_sync)
//   i_s        current stack pointer
//   o_busy     sequence in progress (T0..T6)
//   o_step     current step 0..6 (0 when idle)
//   o_kind     0=RST 1=NMI 2=IRQ 3=BRK (vector actually taken)
//   o_ab_l/h   address for this cycle, valid when o_ab_ovr=1
//   o_ab_ovr   1=o_ab_l/o_ab_h replace PC on the address bus
//   o_rw       1=read, 0=write
//   o_db_sel   data-out source: 0 none, 1 PCH, 2 PCL, 3 P
//   o_b_out    B bit for the pushed P
//   o_s_dec    decrement S at end of cycle
//   o_pcl_ld   load PCL from data bus at end of cycle
//   o_pch_ld   load PCH from data bus at end of cycle
//   o_set_i    set P.I at end of cycle
//   o_done     pulse in the final step
// ----------------------------------------------------------------------------
module intr_seq #(
    parameter logic [15:0] VEC_NMI    = 16'hFFFA,
    parameter logic [15:0] VEC_RST    = 16'hFFFC,
    parameter logic [15:0] VEC_IRQ    = 16'hFFFE,
    parameter logic [7:0]  STACK_PAGE = 8'h01
) (
    input  logic       i_clk,
    input  logic       i_res_n,
    input  logic       i_rdy,
    input  logic       i_sync,
    input  logic       i_nmi_n,
    input  logic       i_irq_n,
    input  logic       i_i_flag,
    input  logic       i_brk_req,
    input  logic [7:0] i_s,
    output logic       o_busy,
    output logic [2:0] o_step,
    output logic [1:0] o_kind,
    output logic [7:0] o_ab_l,
    output logic [7:0] o_ab_h,
    output logic       o_ab_ovr,
    output logic       o_rw,
    output logic [1:0] o_db_sel,
    output logic       o_b_out,
    output logic       o_s_dec,
    output logic       o_pcl_ld,
    output logic       o_pch_ld,
    output logic       o_set_i,
    output logic       o_done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5,
        S_T5   = 3'd6,
        S_T6   = 3'd7
    } state_t;

    localparam logic [1:0] K_RST = 2'd0;
    localparam logic [1:0] K_NMI = 2'd1;
    localparam logic [1:0] K_IRQ = 2'd2;
    localparam logic [1:0] K_BRK = 2'd3;

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_kind,  w_kind_nxt;
    logic        r_brk,   w_brk_nxt;     // original request was BRK (B bit survives a hijack)
    logic        r_nmi_pend, w_nmi_pend_nxt;
    logic        r_rst_pend, w_rst_pend_nxt;
    logic        r_nmi_n_q;

    logic        w_nmi_edge;
    logic        w_nmi_req;
    logic        w_push;
    logic        w_rd_step;
    logic        w_adv;
    logic [15:0] w_vec;
    logic [15:0] w_vec_hi;

    // An edge seen this cycle counts as pending already, so a simultaneous
    // NMI edge beats an IRQ/BRK at the boundary.
    assign w_nmi_edge = r_nmi_n_q & ~i_nmi_n;
    assign w_nmi_req  = r_nmi_pend | w_nmi_edge;

    assign w_push    = (r_state == S_T2) || (r_state == S_T3) || (r_state == S_T4);
    // Reset "pushes" are reads, so they stall on RDY like the other reads.
    assign w_rd_step = ~w_push || (r_kind == K_RST);
    assign w_adv     = ~w_rd_step || i_rdy;

    assign w_vec    = (r_kind == K_NMI) ? VEC_NMI :
                      (r_kind == K_RST) ? VEC_RST : VEC_IRQ;
    assign w_vec_hi = w_vec + 16'd1;

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            r_state    <= S_IDLE;
            r_kind     <= K_RST;
            r_brk      <= 1'b0;
            r_nmi_pend <= 1'b0;
            r_rst_pend <= 1'b1;
            r_nmi_n_q  <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_kind     <= w_kind_nxt;
            r_brk      <= w_brk_nxt;
            r_nmi_pend <= w_nmi_pend_nxt;
            r_rst_pend <= w_rst_pend_nxt;
            r_nmi_n_q  <= i_nmi_n;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_kind_nxt     = r_kind;
        w_brk_nxt      = r_brk;
        w_rst_pend_nxt = r_rst_pend;
        w_nmi_pend_nxt = r_nmi_pend;

        case (r_state)
            S_IDLE: begin
                // Reset entry does not wait for an instruction boundary.
                if (r_rst_pend) begin
                    w_state_nxt    = S_T0;
                    w_kind_nxt     = K_RST;
                    w_brk_nxt      = 1'b0;
                    w_rst_pend_nxt = 1'b0;
                end else if (i_sync) begin
                    if (w_nmi_req) begin
                        w_state_nxt = S_T0;
                        w_kind_nxt  = K_NMI;
                        w_brk_nxt   = 1'b0;
                    end else if (!i_irq_n && !i_i_flag) begin
                        w_state_nxt = S_T0;
                        w_kind_nxt  = K_IRQ;
                        w_brk_nxt   = 1'b0;
                    end else if (i_brk_req) begin
                        w_state_nxt = S_T0;
                        w_kind_nxt  = K_BRK;
                        w_brk_nxt   = 1'b1;
                    end
                end
            end
            S_T6:    if (w_adv) w_state_nxt = S_IDLE;
            default: if (w_adv) w_state_nxt = state_t'(r_state + 3'd1);
        endcase

        // NMI hijack: any NMI seen before the vector fetch redirects IRQ/BRK.
        if ((r_state inside {S_T0, S_T1, S_T2, S_T3, S_T4}) &&
            (r_kind == K_IRQ || r_kind == K_BRK) && w_nmi_req)
            w_kind_nxt = K_NMI;

        // A fresh edge in the clearing cycle keeps the request alive.
        if (w_nmi_edge)
            w_nmi_pend_nxt = 1'b1;
        else if (r_state == S_T5 && r_kind == K_NMI && w_adv)
            w_nmi_pend_nxt = 1'b0;
    end

    always_comb begin
        o_busy   = (r_state != S_IDLE);
        o_step   = o_busy ? 3'(r_state - 3'd1) : 3'd0;
        o_kind   = r_kind;
        o_ab_l   = 8'h00;
        o_ab_h   = 8'h00;
        o_ab_ovr = 1'b0;
        o_rw     = 1'b1;
        o_db_sel = 2'd0;
        o_b_out  = 1'b0;
        o_s_dec  = 1'b0;
        o_pcl_ld = 1'b0;
        o_pch_ld = 1'b0;
        o_set_i  = 1'b0;
        o_done   = 1'b0;

        case (r_state)
            S_T2, S_T3, S_T4: begin
                o_ab_h   = STACK_PAGE;
                o_ab_l   = i_s;
                o_ab_ovr = 1'b1;
                o_s_dec  = w_adv;
                if (r_kind != K_RST) begin
                    o_rw     = 1'b0;
                    o_db_sel = (r_state == S_T2) ? 2'd1 :
                               (r_state == S_T3) ? 2'd2 : 2'd3;
                end
                o_b_out  = (r_state == S_T4) && r_brk;
            end
            S_T5: begin
                {o_ab_h, o_ab_l} = w_vec;
                o_ab_ovr = 1'b1;
                o_pcl_ld = i_rdy;
                o_set_i  = i_rdy;
            end
            S_T6: begin
                {o_ab_h, o_ab_l} = w_vec_hi;
                o_ab_ovr = 1'b1;
                o_pch_ld = i_rdy;
                o_done   = i_rdy;
            end
            default: ;
        endcase
    end

endmodule
